// File: rtl/mux_2to1.sv
// mux_2to1: 2:1 selector with registered copy and select-change monitoring
// Ports:
//   clk      rising-edge clock for all registers
//   rst_n    asynchronous active-low reset
//   D0, D1   data legs chosen by Sel=0 / Sel=1
//   Sel      select
//   out      combinational Sel ? D1 : D0
//   out_r    out registered on clk
//   sel_chg  one-cycle pulse when sampled Sel differs from the previous sample
//   chg_cnt  saturating count of sel_chg pulses
module mux_2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             Sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_r,
    output logic             sel_chg,
    output logic [CNT_W-1:0] chg_cnt
);
    logic sel_q;
    assign out = Sel ? D1 : D0;
    // sel_q resets to 0, so a Sel=1 at the first edge after release counts as a change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= '0;
            sel_q   <= 1'b0;
            sel_chg <= 1'b0;
            chg_cnt <= '0;
        end else begin
            out_r   <= out;
            sel_q   <= Sel;
            sel_chg <= Sel != sel_q;
            if (sel_chg && chg_cnt != '1)
                chg_cnt <= chg_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: scoreboard bench for mux_2to1 against a history-based model
module tb_mux_2to1;
    typedef struct {
        logic [7:0] out_r;
        logic       chg;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] D0, D1;
    logic       Sel;
    logic [7:0] out, out_r, out2, out_r2;
    logic       sel_chg, sel_chg2;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    // model state: last sampled Sel, current pulse, total pulses seen (unsaturated)
    logic       m_last_sel = 1'b0;
    logic       m_chg = 1'b0;
    int         m_pulses = 0;
    logic [7:0] m_out_r = '0;

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .D0(D0), .D1(D1), .Sel(Sel),
        .out(out), .out_r(out_r), .sel_chg(sel_chg), .chg_cnt(chg_cnt)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .D0(D0), .D1(D1), .Sel(Sel),
        .out(out2), .out_r(out_r2), .sel_chg(sel_chg2), .chg_cnt(chg_cnt2)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // one clock of stimulus; expected post-edge state goes to the scoreboard
    task automatic drive(input logic r, input logic [7:0] d0, input logic [7:0] d1,
                         input logic s, input bit glitch);
        @(negedge clk);
        #1;
        rst_n = r;
        D0 = d0;
        D1 = d1;
        Sel = glitch ? ~s : s;
        if (glitch) begin
            #1 chk("glitch_out", out, s ? d0 : d1);
            Sel = s;
        end
        #1;
        chk("out", out, s ? d1 : d0);
        chk("out_sat", out2, s ? d1 : d0);
        if (!r) begin
            chk("rst_out_r", out_r, 0);
            chk("rst_sel_chg", sel_chg, 0);
            chk("rst_chg_cnt", chg_cnt, 0);
            chk("rst_chg_cnt_sat", chg_cnt2, 0);
            m_last_sel = 1'b0;
            m_chg = 1'b0;
            m_pulses = 0;
            m_out_r = '0;
        end else begin
            m_pulses += int'(m_chg);
            m_chg = s != m_last_sel;
            m_last_sel = s;
            m_out_r = s ? d1 : d0;
        end
        sb.push_back('{m_out_r, m_chg,
                       8'(m_pulses > 255 ? 255 : m_pulses),
                       2'(m_pulses > 3 ? 3 : m_pulses)});
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out_r", out_r, e.out_r);
            chk("sel_chg", sel_chg, e.chg);
            chk("chg_cnt", chg_cnt, e.cnt);
            chk("sel_chg_sat", sel_chg2, e.chg);
            chk("chg_cnt_sat", chg_cnt2, e.cnt2);
        end
    end

    initial begin
        rst_n = 1'b0;
        D0 = 8'd0;
        D1 = 8'd1;
        Sel = 1'b0;
        #1 chk("comb_sel0", out, 0);
        chk("rst_init_out_r", out_r, 0);
        chk("rst_init_cnt", chg_cnt, 0);
        Sel = 1'b1;
        #1 chk("comb_sel1", out, 1);
        Sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            D0 = (i % 2 == 0) ? 8'd1 : 8'd0;
            D1 = (i % 2 == 0) ? 8'd0 : 8'd1;
            #5 chk("comb_follow_d0", out, (i % 2 == 0) ? 1 : 0);
        end
        Sel = 1'b1;
        D0 = 8'd0;
        D1 = 8'd1;
        #1 chk("comb_back_d1", out, 1);
        drive(1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
        // release with Sel held low: out_r picks up D0, no pulses
        for (int i = 0; i < 3; i++) drive(1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
        // 0 -> 1 -> 0 with spaced changes: two isolated pulses
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h5a, 8'ha5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h5a, 8'ha5, 1'b0, 1'b0);
        chk("two_pulses", m_pulses, 2);
        drive(1'b0, 8'h00, 8'hff, 1'b0, 1'b0);
        // toggle every clock: narrow counter saturates at 3
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h11, 8'h22, 1'(i % 2 == 0), 1'b0);
        // async reset between edges while sel_chg is high
        drive(1'b0, 8'h33, 8'h44, 1'b1, 1'b0);
        drive(1'b0, 8'h33, 8'h44, 1'b1, 1'b0);
        // first edge after release with Sel=1 counts as a change
        drive(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic s;
            s = ($urandom_range(0, 2) == 0) ? ~m_last_sel : m_last_sel;
            drive(($urandom_range(0, 59) != 0), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), s, ($urandom_range(0, 7) == 0));
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        // long toggle run drives the wide counter into saturation
        for (int i = 0; i < 270; i++)
            drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'(i % 2 == 0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
